// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: widths, sequencer states and decoder opcodes.
package picomips_pkg;

  localparam int PSIZE_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_REL = 2'd2,
    HALT     = 2'd3
  } pc_state_t;

  // Opcode field values shared with the instruction decoder
  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] ADDI = 3'b001;
  localparam logic [2:0] MULI = 3'b010;
  localparam logic [2:0] B    = 3'b011;

endpackage

// File: rtl/sync_ff.sv
// Asynchronous-reset multi-flop synchroniser for a single external input.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/picomips_pc_seq.sv
// picoMIPS program-counter sequencer: increment, relative branch, halt-on-self
// and the input-switch press/release handshake.
module picomips_pc_seq
  import picomips_pkg::*;
#(
  parameter int PSIZE       = PSIZE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             PCincr,
  input  logic             Btaken,
  input  logic [PSIZE-1:0] Boffset,
  input  logic             inp,
  input  logic             INen,
  output logic [PSIZE-1:0] PCout,
  output logic             in_ack,
  output logic             halted,
  output logic             waiting
);

  pc_state_t        state_q, state_d;
  logic [PSIZE-1:0] pc_q, pc_d;
  logic             in_ack_q, in_ack_d;
  logic             halted_q, halted_d;
  logic             waiting_q, waiting_d;
  logic             inen_s;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_inen_sync (
    .clk  (clk),
    .rst_n(nReset),
    .d_i  (INen),
    .q_o  (inen_s)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      in_ack_q  <= 1'b0;
      halted_q  <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      in_ack_q  <= in_ack_d;
      halted_q  <= halted_d;
      waiting_q <= waiting_d;
    end
  end

  // inp outranks any branch or increment the decoder asserts alongside it
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (inp) begin
          state_d = WAIT_IN;
        end else if (Btaken && (Boffset == '0)) begin
          state_d = HALT;
        end
      end
      WAIT_IN:  if (inen_s)  state_d = WAIT_REL;
      WAIT_REL: if (!inen_s) state_d = RUN;
      HALT:     state_d = HALT;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    in_ack_d = 1'b0;
    halted_d = halted_q;
    case (state_q)
      RUN: begin
        if (!inp) begin
          if (Btaken) begin
            if (Boffset == '0) begin
              halted_d = 1'b1;
            end else begin
              pc_d = pc_q + Boffset;
            end
          end else if (PCincr) begin
            pc_d = pc_q + PSIZE'(1);
          end
        end
      end
      WAIT_IN:  in_ack_d = inen_s;
      WAIT_REL: if (!inen_s) pc_d = pc_q + PSIZE'(1);
      default: ;
    endcase
    waiting_d = (state_d == WAIT_IN) || (state_d == WAIT_REL);
  end

  assign PCout   = pc_q;
  assign in_ack  = in_ack_q;
  assign halted  = halted_q;
  assign waiting = waiting_q;

endmodule

// File: tb/tb_picomips_pc_seq.sv
// Directed-vector bench for the picoMIPS PC sequencer with hand-computed expectations.
module tb_picomips_pc_seq;

  logic       clk     = 1'b0;
  logic       nReset  = 1'b0;
  logic       PCincr  = 1'b0;
  logic       Btaken  = 1'b0;
  logic [7:0] Boffset = 8'h00;
  logic       inp     = 1'b0;
  logic       INen    = 1'b0;
  logic [7:0] PCout;
  logic       in_ack;
  logic       halted;
  logic       waiting;

  int   checks     = 0;
  int   errors     = 0;
  int   ack_cnt    = 0;
  int   consec_cnt = 0;
  logic prev_ack   = 1'b0;

  picomips_pc_seq #(
    .PSIZE      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .PCincr (PCincr),
    .Btaken (Btaken),
    .Boffset(Boffset),
    .inp    (inp),
    .INen   (INen),
    .PCout  (PCout),
    .in_ack (in_ack),
    .halted (halted),
    .waiting(waiting)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input integer got, input integer exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("chk  %s got=%0d", tag, got);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; tally in_ack pulses
  task automatic tick();
    @(posedge clk);
    #1;
    if (in_ack === 1'b1) begin
      ack_cnt++;
      if (prev_ack) consec_cnt++;
    end
    prev_ack = (in_ack === 1'b1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic branch(input logic [7:0] off);
    Btaken  = 1'b1;
    Boffset = off;
    tick();
    Btaken  = 1'b0;
    Boffset = 8'h00;
  endtask

  initial begin
    #2;
    check("rst_pc", integer'(PCout), 0);
    check("rst_halted", integer'(halted), 0);
    check("rst_ack", integer'(in_ack), 0);
    check("rst_wait", integer'(waiting), 0);
    tick();
    nReset = 1'b1;

    // Sequential increment
    PCincr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("incr_pc", integer'(PCout), i);
      check("incr_halted", integer'(halted), 0);
      check("incr_ack", integer'(in_ack), 0);
    end
    #3 nReset = 1'b0;
    #1 check("rst_mid_pc", integer'(PCout), 0);
    PCincr = 1'b0;
    tick();
    nReset = 1'b1;

    // Relative branches and wrap-around
    branch(8'd10);
    check("br_to_10", integer'(PCout), 10);
    branch(8'hFD);
    check("br_m3", integer'(PCout), 7);
    branch(8'hF9);
    check("br_m7", integer'(PCout), 0);
    branch(8'hFF);
    check("br_m1_wrap", integer'(PCout), 255);
    PCincr = 1'b1;
    tick();
    PCincr = 1'b0;
    check("incr_wrap", integer'(PCout), 0);

    // Single input wait: press, hold, release
    branch(8'd4);
    check("br_to_4", integer'(PCout), 4);
    inp = 1'b1;
    tick();
    inp = 1'b0;
    check("wait_enter_pc", integer'(PCout), 4);
    check("wait_enter_w", integer'(waiting), 1);
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wait_idle_pc", integer'(PCout), 4);
      check("wait_idle_w", integer'(waiting), 1);
    end
    check("wait_idle_acks", ack_cnt, 0);
    INen = 1'b1;
    tick();
    check("ack_lat1", integer'(in_ack), 0);
    tick();
    check("ack_lat2", integer'(in_ack), 0);
    tick();
    check("ack_lat3", integer'(in_ack), 1);
    tick();
    check("ack_lat4", integer'(in_ack), 0);
    ticks(2);
    check("hold_pc", integer'(PCout), 4);
    check("hold_acks", ack_cnt, 1);
    INen = 1'b0;
    tick();
    check("rel1_pc", integer'(PCout), 4);
    tick();
    check("rel2_pc", integer'(PCout), 4);
    tick();
    check("rel3_pc", integer'(PCout), 5);
    check("rel3_w", integer'(waiting), 0);
    check("rel3_ack", integer'(in_ack), 0);

    // Back-to-back inp with the switch held high
    ack_cnt = 0;
    inp  = 1'b1;
    INen = 1'b1;
    tick();
    check("b2b_w", integer'(waiting), 1);
    ticks(2);
    check("b2b_ack1", integer'(in_ack), 1);
    ticks(8);
    check("b2b_held_pc", integer'(PCout), 5);
    check("b2b_held_acks", ack_cnt, 1);
    INen = 1'b0;
    ticks(3);
    check("b2b_adv_pc", integer'(PCout), 6);
    tick();
    check("b2b_rewait", integer'(waiting), 1);
    ticks(5);
    check("b2b_low_acks", ack_cnt, 1);
    check("b2b_low_pc", integer'(PCout), 6);
    INen = 1'b1;
    ticks(3);
    check("b2b_ack2", integer'(in_ack), 1);
    check("b2b_acks2", ack_cnt, 2);
    INen = 1'b0;
    inp  = 1'b0;
    ticks(3);
    check("b2b_done_pc", integer'(PCout), 7);
    check("b2b_done_w", integer'(waiting), 0);

    // Branch-to-self halts; inputs are ignored
    branch(8'd13);
    check("br_to_20", integer'(PCout), 20);
    branch(8'd0);
    check("halt_flag", integer'(halted), 1);
    check("halt_pc", integer'(PCout), 20);
    for (int i = 0; i < 8; i++) begin
      PCincr  = ((i & 1) != 0);
      Btaken  = ((i & 2) != 0);
      inp     = ((i & 4) != 0);
      Boffset = 8'(i * 3);
      INen    = ~INen;
      tick();
      check("halt_frz_pc", integer'(PCout), 20);
      check("halt_frz_flag", integer'(halted), 1);
      check("halt_frz_ack", integer'(in_ack), 0);
    end
    PCincr = 1'b0; Btaken = 1'b0; inp = 1'b0; Boffset = 8'h00; INen = 1'b0;
    nReset = 1'b0;
    #1;
    check("halt_rst_pc", integer'(PCout), 0);
    check("halt_rst_flag", integer'(halted), 0);
    tick();
    nReset = 1'b1;

    // inp outranks Btaken and PCincr
    branch(8'd9);
    check("br_to_9", integer'(PCout), 9);
    inp = 1'b1; Btaken = 1'b1; Boffset = 8'd3; PCincr = 1'b1;
    tick();
    inp = 1'b0; Btaken = 1'b0; Boffset = 8'h00; PCincr = 1'b0;
    check("prio_pc", integer'(PCout), 9);
    check("prio_w", integer'(waiting), 1);
    check("prio_halted", integer'(halted), 0);

    // Reset clears an in-flight acknowledge
    INen = 1'b1;
    ticks(3);
    check("inflt_ack", integer'(in_ack), 1);
    nReset = 1'b0;
    #1;
    check("inflt_rst_ack", integer'(in_ack), 0);
    check("inflt_rst_w", integer'(waiting), 0);
    check("inflt_rst_pc", integer'(PCout), 0);
    INen = 1'b0;
    tick();
    nReset = 1'b1;

    check("no_consec_ack", consec_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/picomips_pc_seq.md
Name: picomips_pc_seq

Overview:
- Program-counter sequencer for picoMIPS. It sits on the far side of the instruction decoder.
- It consumes the decoder's PCincr, branch and input-wait controls, plus the external input-enable switch.
- It produces the program-memory address that feeds the opcode back into the decoder.
- It owns all sequential control flow: increment, relative branch, halt-on-self-branch, and the input-switch press/release handshake.

Parameters:
- PSIZE, 8, PC width in bits; address space 2^PSIZE words.
- SYNC_STAGES, 2, flip-flop stages in the INen synchroniser (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- PCincr  input  1  decoder: advance PC by 1 this cycle.
- Btaken  input  1  decoder: branch taken this cycle (decoder has already qualified it with Ben/Bflag).
- Boffset  input  PSIZE  signed two's-complement branch offset, relative to the current PC.
- inp  input  1  decoder: the current instruction waits for a switch press.
- INen  input  1  asynchronous external switch, level-sensitive.
- PCout  output  PSIZE  program-memory address (registered).
- in_ack  output  1  one-cycle pulse; the input value is to be written to the register file.
- halted  output  1  set by a branch-to-self; sticky until reset.
- waiting  output  1  high while the sequencer is in WAIT_IN or WAIT_REL.

Behaviour:
- Reset: while nReset=0, asynchronously PCout=0, in_ack=0, halted=0, waiting=0, state=RUN, synchroniser flops=0.
- INen passes through a SYNC_STAGES-deep synchroniser to give INen_s. The FSM uses only INen_s.
- All outputs are registered. A new PCout appears the cycle after the controlling inputs are sampled.
- FSM states: RUN, WAIT_IN, WAIT_REL, HALT.
- RUN, priority from highest to lowest:
  - inp=1: PC holds; go to WAIT_IN.
  - Btaken=1 and Boffset=0: PC holds; halted<=1; go to HALT.
  - Btaken=1: PC <= PC + sign-extended Boffset, modulo 2^PSIZE.
  - PCincr=1: PC <= PC+1, wrapping from 2^PSIZE-1 to 0.
  - Otherwise: PC holds.
  - inp overrides Btaken/PCincr if the decoder asserts them together.
- WAIT_IN: PC holds; waiting=1. On INen_s=1, in_ack<=1 for exactly one cycle and go to WAIT_REL.
- WAIT_REL: PC holds; waiting=1; in_ack=0. On INen_s=0, PC <= PC+1 and go to RUN.
  - A switch held high therefore cannot satisfy two consecutive inp instructions; each needs its own press.
- HALT: PC, halted and in_ack=0 are frozen. Inputs are ignored. Only reset exits HALT.
- in_ack never asserts outside the WAIT_IN→WAIT_REL transition and is never high for two consecutive cycles.
- Branch arithmetic: Boffset of -1 from PC=0 gives PC=2^PSIZE-1. Overflow wraps silently.
- Reset mid-operation: any state returns to RUN with PC=0 immediately (asynchronous). An in-flight in_ack is cleared.
- Latency from an INen pin rise to in_ack is SYNC_STAGES+1 cycles.

Decomposition:
- Package picomips_pkg holds:
  - PSIZE default;
  - enum pc_state_t {RUN, WAIT_IN, WAIT_REL, HALT};
  - the opcode constants shared with the decoder (ADD, ADDI, MULI, B).
- Sub-module sync_ff (parameter SYNC_STAGES): an asynchronous-reset synchroniser chain for INen, reused for later external inputs.
- The rest of the block is a single FSM + PC register.

Test Plan:
- Reset then 5 cycles with PCincr=1 → PCout 0,1,2,3,4,5; halted=0, in_ack=0 throughout. Assert nReset=0 mid-count → PCout=0 the same cycle.
- PC=10, Btaken=1, Boffset=-3 (8'hFD) → PCout=7 next cycle. PC=0, Boffset=-1 → PCout=255. PC=255, PCincr → PCout=0.
- PC=4, inp=1, INen=0 for 10 cycles → PCout stays 4, waiting=1. Raise INen → in_ack pulses once, exactly 3 cycles later (SYNC_STAGES=2). Hold INen 6 cycles: PC=4, no further in_ack. Drop INen → PCout=5 at SYNC_STAGES+1 cycles, waiting=0.
- Two back-to-back inp instructions with INen held high between them → first in_ack; the second waits in WAIT_IN until INen falls and rises again.
- PC=20, Btaken=1, Boffset=0 → halted=1, PCout=20 frozen. Apply PCincr/Btaken/inp/INen toggles → no change. nReset pulse → PCout=0, halted=0.
- Simultaneous inp=1, Btaken=1, PCincr=1 at PC=9 → WAIT_IN entered, PCout=9 (inp priority).
